// File: rtl/hazard_scoreboard_if.sv
// D-stage hazard query bus: decoder operand/destination info in, stall and
// forward selects plus mult/div occupancy out.
interface hazard_scoreboard_if #(
   parameter int TW = 3,
   parameter int FW = 2
);
   logic [4:0]    d_rs;
   logic [4:0]    d_rt;
   logic [TW-1:0] d_t_use_rs;
   logic [TW-1:0] d_t_use_rt;
   logic [4:0]    d_target;
   logic [TW-1:0] d_t_new;
   logic          d_md_start;
   logic          d_md_is_div;
   logic          d_md_use;
   logic          stall;
   logic [FW-1:0] fwd_rs;
   logic [FW-1:0] fwd_rt;
   logic          md_busy;

   modport master (
      output d_rs, d_rt, d_t_use_rs, d_t_use_rt, d_target, d_t_new,
             d_md_start, d_md_is_div, d_md_use,
      input  stall, fwd_rs, fwd_rt, md_busy
   );

   modport slave (
      input  d_rs, d_rt, d_t_use_rs, d_t_use_rt, d_target, d_t_new,
             d_md_start, d_md_is_div, d_md_use,
      output stall, fwd_rs, fwd_rt, md_busy
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// Stall/forward unit: shift register of in-flight destinations and result
// latencies for stages E..W, plus a busy counter for the mult/div unit.
module hazard_scoreboard #(
   parameter int STAGES   = 3,
   parameter int TW       = 3,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT  = 10,
   parameter int FW       = $clog2(STAGES + 1)
) (
   input logic                clk,
   input logic                reset,
   hazard_scoreboard_if.slave hs
);
   localparam int CW = $clog2(DIV_LAT + 1);

   typedef struct packed {
      logic [4:0]    target;
      logic [TW-1:0] t_new;
      logic [1:0]    md;
   } entry_t;

   localparam logic [1:0] MD_NONE = 2'b00;
   localparam logic [1:0] MD_MULT = 2'b01;
   localparam logic [1:0] MD_DIV  = 2'b10;

   entry_t        ent_q [1:STAGES];
   entry_t        ent_d [1:STAGES];
   logic [CW-1:0] md_cnt_q, md_cnt_d;

   logic          hit_rs, hit_rt;
   logic [TW-1:0] tnew_rs, tnew_rt;
   logic [FW-1:0] idx_rs, idx_rt;
   logic          stall_rs, stall_rt, stall_md, stall;
   logic          md_busy;
   logic [1:0]    md_new;

   // Scan oldest to youngest so the youngest matching entry wins.
   always_comb begin
      hit_rs  = 1'b0;
      hit_rt  = 1'b0;
      tnew_rs = '0;
      tnew_rt = '0;
      idx_rs  = '0;
      idx_rt  = '0;
      for (int k = STAGES; k >= 1; k--) begin
         if (hs.d_rs != 5'd0 && ent_q[k].target == hs.d_rs) begin
            hit_rs  = 1'b1;
            tnew_rs = ent_q[k].t_new;
            idx_rs  = FW'(k);
         end
         if (hs.d_rt != 5'd0 && ent_q[k].target == hs.d_rt) begin
            hit_rt  = 1'b1;
            tnew_rt = ent_q[k].t_new;
            idx_rt  = FW'(k);
         end
      end
   end

   always_comb begin
      md_busy  = (md_cnt_q != '0) || (ent_q[1].md != MD_NONE);
      stall_rs = hit_rs && (tnew_rs > hs.d_t_use_rs);
      stall_rt = hit_rt && (tnew_rt > hs.d_t_use_rt);
      stall_md = hs.d_md_use && md_busy;
      stall    = stall_rs || stall_rt || stall_md;
   end

   assign hs.stall   = stall;
   assign hs.md_busy = md_busy;
   assign hs.fwd_rs  = (hit_rs && tnew_rs == '0) ? idx_rs : '0;
   assign hs.fwd_rt  = (hit_rt && tnew_rt == '0) ? idx_rt : '0;

   always_comb begin
      md_new = MD_NONE;
      if (hs.d_md_start)
         md_new = hs.d_md_is_div ? MD_DIV : MD_MULT;
   end

   // A stalled D instruction leaves a bubble in E; D holds it for next cycle.
   always_comb begin
      for (int k = 1; k <= STAGES; k++)
         ent_d[k] = '0;
      if (!stall) begin
         ent_d[1].target = hs.d_target;
         ent_d[1].t_new  = hs.d_t_new;
         ent_d[1].md     = md_new;
      end
      for (int k = 2; k <= STAGES; k++) begin
         ent_d[k]       = ent_q[k-1];
         ent_d[k].t_new = (ent_q[k-1].t_new != '0) ? ent_q[k-1].t_new - TW'(1) : '0;
      end
   end

   always_comb begin
      md_cnt_d = md_cnt_q;
      if (ent_q[1].md == MD_DIV)
         md_cnt_d = CW'(DIV_LAT);
      else if (ent_q[1].md == MD_MULT)
         md_cnt_d = CW'(MULT_LAT);
      else if (md_cnt_q != '0)
         md_cnt_d = md_cnt_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 1; k <= STAGES; k++)
            ent_q[k] <= '0;
         md_cnt_q <= '0;
      end else begin
         for (int k = 1; k <= STAGES; k++)
            ent_q[k] <= ent_d[k];
         md_cnt_q <= md_cnt_d;
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: vector table through a scoreboard queue on the
// default 3-stage unit, plus hand sequences for divide busy and a 5-stage unit.
module tb_hazard_scoreboard;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   hazard_scoreboard_if #(.TW(3), .FW(2)) hif ();
   hazard_scoreboard_if #(.TW(3), .FW(3)) hif5 ();

   hazard_scoreboard #(.STAGES(3)) u_dut (
      .clk   (clk),
      .reset (reset),
      .hs    (hif)
   );

   hazard_scoreboard #(.STAGES(5)) u_dut5 (
      .clk   (clk),
      .reset (reset),
      .hs    (hif5)
   );

   typedef struct {
      logic [4:0] rs, rt, tgt;
      logic [2:0] tur, tut, tnew;
      logic       mds, mdd, mdu, rst;
      logic       st;
      logic [1:0] frs, frt;
      logic       bsy;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input int rs, rt, tur, tut, tgt, tnew,
                               input int mds, mdd, mdu, rst,
                               input int st, frs, frt, bsy);
      vec_t v;
      v.rs = 5'(rs);   v.rt = 5'(rt);   v.tur = 3'(tur); v.tut = 3'(tut);
      v.tgt = 5'(tgt); v.tnew = 3'(tnew);
      v.mds = 1'(mds); v.mdd = 1'(mdd); v.mdu = 1'(mdu); v.rst = 1'(rst);
      v.st = 1'(st);   v.frs = 2'(frs); v.frt = 2'(frt); v.bsy = 1'(bsy);
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      hif.d_rs        = v.rs;
      hif.d_rt        = v.rt;
      hif.d_t_use_rs  = v.tur;
      hif.d_t_use_rt  = v.tut;
      hif.d_target    = v.tgt;
      hif.d_t_new     = v.tnew;
      hif.d_md_start  = v.mds;
      hif.d_md_is_div = v.mdd;
      hif.d_md_use    = v.mdu;
      reset           = v.rst;
   endtask

   task automatic drive5(input int rs, tur, tgt, tnew);
      hif5.d_rs        = 5'(rs);
      hif5.d_rt        = 5'd0;
      hif5.d_t_use_rs  = 3'(tur);
      hif5.d_t_use_rt  = 3'd7;
      hif5.d_target    = 5'(tgt);
      hif5.d_t_new     = 3'(tnew);
      hif5.d_md_start  = 1'b0;
      hif5.d_md_is_div = 1'b0;
      hif5.d_md_use    = 1'b0;
   endtask

   task automatic apply(input int idx, input vec_t v);
      vec_t e;
      drive(v);
      exp_q.push_back(v);
      @(negedge clk);
      if (exp_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL sb_empty v%0d got=0 want=1", idx);
      end else begin
         e = exp_q.pop_front();
         check($sformatf("stall v%0d", idx),   32'(hif.stall),   32'(e.st));
         check($sformatf("fwd_rs v%0d", idx),  32'(hif.fwd_rs),  32'(e.frs));
         check($sformatf("fwd_rt v%0d", idx),  32'(hif.fwd_rt),  32'(e.frt));
         check($sformatf("md_busy v%0d", idx), 32'(hif.md_busy), 32'(e.bsy));
      end
      @(posedge clk); #1;
   endtask

   initial begin
      vec_t nop;
      int   cnt;
      nop = mk(0,0,7,7,0,0, 0,0,0,0, 0,0,0,0);

      // lw $1 then dependent add: one stall, no forward while t_new>0
      tbl.push_back(mk(2,0,1,7,1,2, 0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(1,3,1,1,2,1, 0,0,0,0, 1,0,0,0));
      tbl.push_back(mk(1,3,1,1,2,1, 0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(1,2,1,1,4,1, 0,0,0,0, 0,3,0,0));
      tbl.push_back(nop); tbl.push_back(nop); tbl.push_back(nop);
      // add $1 then beq $1: stall, then forward from M
      tbl.push_back(mk(2,3,1,1,1,1, 0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 1,0,0,0));
      tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 0,2,0,0));
      tbl.push_back(nop);
      // add $5, ori $5, sw rt=$5: youngest match governs
      tbl.push_back(mk(2,3,1,1,5,1, 0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(6,0,1,7,5,1, 0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(7,5,1,2,0,0, 0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(7,5,1,2,0,0, 0,0,0,0, 0,0,2,0));
      tbl.push_back(nop);
      // mult then mflo: 6 busy stall cycles, issues on the 7th
      tbl.push_back(mk(2,3,1,1,0,0, 1,0,1,0, 0,0,0,0));
      for (int i = 0; i < 6; i++)
         tbl.push_back(mk(0,0,7,7,4,1, 0,0,1,0, 1,0,0,1));
      tbl.push_back(mk(0,0,7,7,4,1, 0,0,1,0, 0,0,0,0));
      tbl.push_back(nop); tbl.push_back(nop); tbl.push_back(nop);
      // writes to $0 are invisible
      tbl.push_back(mk(2,3,1,1,0,1, 0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(0,0,0,0,6,1, 0,0,0,0, 0,0,0,0));
      // reset while md_cnt=3 with a pending lw $7
      tbl.push_back(mk(2,3,1,1,0,0, 1,0,0,0, 0,0,0,0));
      tbl.push_back(mk(0,0,7,7,0,0, 0,0,0,0, 0,0,0,1));
      tbl.push_back(mk(0,0,7,7,0,0, 0,0,0,0, 0,0,0,1));
      tbl.push_back(mk(2,0,1,7,7,2, 0,0,0,0, 0,0,0,1));
      tbl.push_back(mk(0,0,7,7,0,0, 0,0,0,1, 0,0,0,1));
      tbl.push_back(mk(7,0,0,7,0,0, 0,0,1,0, 0,0,0,0));
      // rt-side hazard
      tbl.push_back(mk(2,0,1,7,8,2, 0,0,0,0, 0,0,0,0));
      tbl.push_back(mk(3,8,1,1,0,0, 0,0,0,0, 1,0,0,0));
      tbl.push_back(mk(3,8,1,1,0,0, 0,0,0,0, 0,0,0,0));
      tbl.push_back(nop);

      drive(nop);
      reset = 1'b1;
      drive5(0, 7, 0, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst stall",   32'(hif.stall),   32'd0);
      check("rst fwd_rs",  32'(hif.fwd_rs),  32'd0);
      check("rst fwd_rt",  32'(hif.fwd_rt),  32'd0);
      check("rst md_busy", 32'(hif.md_busy), 32'd0);
      check("rst5 stall",  32'(hif5.stall),  32'd0);
      @(posedge clk); #1;

      for (int i = 0; i < tbl.size(); i++)
         apply(i, tbl[i]);

      // div then mflo: stalls while the div sits in E plus DIV_LAT cycles
      drive(mk(2,3,1,1,0,0, 1,1,1,0, 0,0,0,0));
      @(negedge clk);
      check("div issue stall", 32'(hif.stall), 32'd0);
      @(posedge clk); #1;
      drive(mk(0,0,7,7,4,1, 0,0,1,0, 0,0,0,0));
      cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!hif.stall) break;
         cnt++;
         @(posedge clk); #1;
      end
      check("div stall cycles", 32'(cnt), 32'd11);
      check("div busy end", 32'(hif.md_busy), 32'd0);
      @(posedge clk); #1;
      drive(nop);

      // 5-stage unit: t_new=4 producer, t_use=0 consumer
      drive5(2, 1, 9, 4);
      @(negedge clk);
      check("s5 issue stall", 32'(hif5.stall), 32'd0);
      @(posedge clk); #1;
      drive5(9, 0, 10, 1);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!hif5.stall) break;
         cnt++;
         @(posedge clk); #1;
      end
      check("s5 stall cycles", 32'(cnt), 32'd4);
      check("s5 fwd_rs", 32'(hif5.fwd_rs), 32'd5);
      check("s5 fwd_rt", 32'(hif5.fwd_rt), 32'd0);
      @(posedge clk); #1;
      drive5(0, 7, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised stall/forward unit for the pipelined MIPS core.
- Tracks every in-flight instruction's destination register and remaining result latency (t_new) in a STAGES-deep shift register that mirrors the E..W stages.
- Compares these against the D-stage decoder's rs/rt/t_use and generates stall plus D-stage forward selects.
- Also models a multi-cycle mult/div unit with a busy counter, for the HI/LO instruction extension.

Parameters:
- STAGES, 3, number of tracked stages after D (1=E, 2=M, 3=W); legal range 2..6.
- TW, 3, width of t_use/t_new fields.
- MULT_LAT, 5, busy cycles after a mult/multu leaves E.
- DIV_LAT, 10, busy cycles after a div/divu leaves E.
- FW, $clog2(STAGES+1), width of each forward select.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clears all state.
- d_rs  in  5  D-stage source register 1.
- d_rt  in  5  D-stage source register 2.
- d_t_use_rs  in  TW  cycles until rs is needed; 7 means unused.
- d_t_use_rt  in  TW  cycles until rt is needed; 7 means unused.
- d_target  in  5  D-stage destination register; 0 means none.
- d_t_new  in  TW  result latency measured at entry to E.
- d_md_start  in  1  D instruction is mult/multu/div/divu.
- d_md_is_div  in  1  qualifies d_md_start: 1=div, 0=mult.
- d_md_use  in  1  D instruction is mfhi/mflo/mthi/mtlo/mult/div.
- stall  out  1  freeze F/D; insert bubble into E.
- fwd_rs  out  FW  0=GRF, k=forward from stage k.
- fwd_rt  out  FW  0=GRF, k=forward from stage k.
- md_busy  out  1  mult/div unit occupied.

Behaviour:
- Entry state: entry[k], k=1..STAGES, each holding {target[4:0], t_new[TW-1:0], md[1:0]}. md: 00=none, 01=mult, 10=div.
- Reset: all entries zeroed, md_cnt=0. Outputs are combinational from state: after reset stall=0, fwd_rs=fwd_rt=0, md_busy=0.
- Shift, every non-reset edge:
  - entry[k] <= entry[k-1] with t_new saturating decrement (max(t_new-1,0)), for k>=2.
  - entry[1] <= {d_target, d_t_new, md} when stall=0.
  - entry[1] <= all-zero bubble when stall=1.
  - The oldest entry falls off.
- Register-hazard stall, for operand r in {rs, rt}: r!=0, some entry k has target==r, entry[k].t_new > d_t_use_r, and no younger entry j<k has target==r. Only the youngest matching entry counts.
- Forward select: fwd_r = k where k is the youngest entry with target==r and t_new==0; 0 if r==0, if no match, or if the youngest match has t_new>0.
- md_cnt (width $clog2(DIV_LAT+1)) update, one rule per edge, in priority order:
  1. If entry[1].md!=0, load MULT_LAT or DIV_LAT.
  2. Else if md_cnt!=0, decrement.
- md_busy = (md_cnt!=0) | (entry[1].md!=0).
- MD stall: d_md_use & md_busy.
- stall = rs-stall | rt-stall | MD stall.
- Simultaneous events: stall has priority over issue. A stalled D instruction is never entered twice, because D holds and entry[1] receives a bubble.
- Target 0: never matches and never forwards; writes to $0 are invisible.
- Reset mid-mult: busy drops on the cycle after reset is sampled.
- Latency: stall and fwd are 0-cycle combinational from D inputs and current state. All state updates take 1 cycle.

Test Plan:
- lw $1 (d_t_new=2) issued, then add $2,$1,$3 (t_use_rs=1) in D -> stall=1 for exactly 1 cycle. Next cycle stall=0, fwd_rs=0. Entry[1] shows a bubble.
- add $1 (t_new=1), then beq $1,$0 (t_use_rs=0) -> stall=1 one cycle. Then fwd_rs=2 (M) with stall=0.
- add $5 (t_new=1), then ori $5 (t_new=1), then sw using $5 as rt (t_use=2) -> no stall. fwd_rt selects the ori entry, never the older add.
- Issue mult with MULT_LAT=5, followed by mflo -> md_busy=1 for 6 cycles after mult enters E. mflo stalls all 6; issues on the 7th.
- add $0 then immediately use $0 -> stall=0, fwd_rs=0. Separately, assert reset while md_cnt=3 -> all entries zero, md_busy=0 next cycle.
- Parameter sweep STAGES=5: lw-style t_new=4 producer, consumer t_use=0 -> stall for 4 cycles, then fwd=5 on the last stage.
